// File: rtl/ysyx_24080014_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the boot PC and the fault-cause codes reported to the trap logic.
package ysyx_24080014_pkg;

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_REQ   = 3'd1,
        S_RESP  = 3'd2,
        S_OUT   = 3'd3,
        S_WAIT  = 3'd4,
        S_FAULT = 3'd5
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam logic FC_ACCESS   = 1'b0;
    localparam logic FC_MISALIGN = 1'b1;

endpackage

// File: rtl/ysyx_24080014_pc_reg.sv
// Architectural PC register with load enable and alignment handling.
// Optional macro IFU_MISALIGN_TRAP_EN: when defined, a misaligned target is
// loaded unmodified and flagged on o_trap; otherwise the low two bits are
// cleared on load and o_trap is constant 0.
module ysyx_24080014_pc_reg
    import ysyx_24080014_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_next_pc,
    output logic [XLEN-1:0] o_pc,
    output logic            o_trap
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_load_val;

`ifdef IFU_MISALIGN_TRAP_EN
    // Keep the offending value so the handler can see exactly where it came from
    assign w_load_val = i_next_pc;
    assign o_trap     = |i_next_pc[1:0];
`else
    // Without the trap path every target is forced onto a word boundary
    assign w_load_val = i_next_pc & ~XLEN'(3);
    assign o_trap     = 1'b0;
`endif

    // PC register: boot value on reset, new target whenever a redirect is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= w_load_val;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem request per redirect,
// hands the returned word to decode and waits for the next-PC selector.
// Optional macro IFU_MISALIGN_TRAP_EN enables the misaligned-target fault.
module ysyx_24080014_ifu
    import ysyx_24080014_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] next_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    output logic            imem_resp_ready,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault,
    output logic            fault_cause,
    output logic [31:0]     fetch_cnt
);

    ifu_state_t      r_state;
    ifu_state_t      w_state_nxt;
    logic [XLEN-1:0] w_pc;
    logic            w_trap;
    logic            w_redirect;
    logic            w_resp_fire;
    logic            w_handoff;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_fault;
    logic [31:0]     r_fetch_cnt;

    // A redirect is only taken once the current instruction has left the IFU
    assign w_redirect  = npc_valid && ((r_state == S_WAIT) || (r_state == S_FAULT) ||
                                       ((r_state == S_OUT) && inst_ready));
    assign w_resp_fire = (r_state == S_RESP) && imem_resp_valid;
    assign w_handoff   = (r_state == S_OUT) && inst_ready;

    ysyx_24080014_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_redirect),
        .i_next_pc (next_pc),
        .o_pc      (w_pc),
        .o_trap    (w_trap)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_REQ;
            S_REQ:   if (imem_req_ready) w_state_nxt = S_RESP;
            S_RESP:  if (imem_resp_valid) w_state_nxt = imem_resp_err ? S_FAULT : S_OUT;
            S_OUT:   if (inst_ready) begin
                         if (npc_valid) w_state_nxt = w_trap ? S_FAULT : S_REQ;
                         else           w_state_nxt = S_WAIT;
                     end
            S_WAIT:  if (npc_valid) w_state_nxt = w_trap ? S_FAULT : S_REQ;
            S_FAULT: if (npc_valid) w_state_nxt = w_trap ? S_FAULT : S_REQ;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // FSM handshake outputs, forced low while reset is asserted
    always_comb begin
        imem_req_valid  = 1'b0;
        imem_resp_ready = 1'b0;
        inst_valid      = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_REQ:   imem_req_valid  = 1'b1;
                S_RESP:  imem_resp_ready = 1'b1;
                S_OUT:   inst_valid      = 1'b1;
                default: ;
            endcase
        end
    end

    // Instruction/PC capture; a misaligned trap exposes the bad target on inst_pc
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else if (w_resp_fire && !imem_resp_err) begin
            r_inst    <= imem_resp_data;
            r_inst_pc <= w_pc;
        end else if (w_redirect && w_trap) begin
            r_inst_pc <= next_pc;
        end
    end

    // Fault flag: set by a faulting response or trapped target, cleared by a clean redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_resp_fire && imem_resp_err) begin
            r_fault <= 1'b1;
        end else if (w_redirect) begin
            r_fault <= w_trap;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    logic r_cause;

    // Fault cause: remembers which of the two fault sources fired last
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cause <= FC_ACCESS;
        end else if (w_resp_fire && imem_resp_err) begin
            r_cause <= FC_ACCESS;
        end else if (w_redirect && w_trap) begin
            r_cause <= FC_MISALIGN;
        end
    end

    assign fault_cause = r_cause;
`else
    assign fault_cause = FC_ACCESS;
`endif

    // Count of instructions accepted by decode, free-running with wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
        end else if (w_handoff) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign imem_req_addr = w_pc;
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign fetch_fault   = r_fault;
    assign fetch_cnt     = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// Self-checking bench for ysyx_24080014_ifu. Memory responder with
// configurable latency/error; scenario tasks check against a fetch model.
// Honours IFU_MISALIGN_TRAP_EN the same way the design does.
`timescale 1ns/1ps
module tb_ysyx_24080014_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        npc_valid;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;
    logic        fault_cause;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    int          cfg_req_lat  = 0;
    int          cfg_resp_lat = 0;
    bit          cfg_err      = 0;
    int          req_count    = 0;
    bit          m_pending;
    int          m_wait;
    logic [31:0] m_addr;

    ysyx_24080014_ifu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .npc_valid       (npc_valid),
        .next_pc         (next_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_ready (imem_resp_ready),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault),
        .fault_cause     (fault_cause),
        .fetch_cnt       (fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents as seen by the bench
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h0000_0413;
        return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] a;
        a = RST_PC | ($urandom_range(0, 1023) << 2);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // Memory responder: decides at each falling edge what the next rising edge sees
    initial begin
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        m_pending = 1'b0;
        m_wait    = 0;
        m_addr    = '0;
        forever begin
            @(negedge clk);
            imem_req_ready  = 1'b0;
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            if (!rst_n) begin
                m_pending = 1'b0;
                m_wait    = 0;
            end else if (!m_pending) begin
                if (imem_req_valid) begin
                    if (m_wait >= cfg_req_lat) begin
                        imem_req_ready = 1'b1;
                        m_pending = 1'b1;
                        m_wait    = 0;
                        m_addr    = imem_req_addr;
                        req_count++;
                    end else begin
                        m_wait++;
                    end
                end
            end else if (m_wait >= cfg_resp_lat) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(m_addr);
                imem_resp_err   = cfg_err;
                if (imem_resp_ready) begin
                    m_pending = 1'b0;
                    m_wait    = 0;
                end
            end else begin
                m_wait++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_redirect(input logic [31:0] a);
        npc_valid = 1'b1;
        next_pc   = a;
        tick();
        npc_valid = 1'b0;
        next_pc   = $urandom;
    endtask

    task automatic wait_event(input int budget, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            if (inst_valid || fetch_fault) seen = 1'b1;
            else begin
                tick();
                cycles++;
            end
        end
    endtask

    task automatic take_inst();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; npc_valid = 1'b0; next_pc = '0; inst_ready = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({imem_req_valid, imem_resp_ready, inst_valid, fetch_fault, fault_cause} !== 5'b0) begin
            n_errors++; $display("FAIL reset_flags: got %b required 00000",
                {imem_req_valid, imem_resp_ready, inst_valid, fetch_fault, fault_cause});
        end
        n_checks++;
        if (fetch_cnt !== 32'd0) begin
            n_errors++; $display("FAIL reset_cnt: got %0d required 0", fetch_cnt);
        end
        n_checks++;
        if ({inst, inst_pc} !== 64'd0) begin
            n_errors++; $display("FAIL reset_inst: got %h/%h required 0/0", inst, inst_pc);
        end
    endtask

    task automatic test_first_fetch();
        int cyc;
        bit seen;
        inst_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL boot_noreq: got %b required 0", imem_req_valid);
        end
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            n_errors++; $display("FAIL boot_req: got %b/%h required 1/%h", imem_req_valid, imem_req_addr, RST_PC);
        end
        wait_event(20, cyc, seen);
        n_checks++;
        if (!seen || !inst_valid || cyc != 2) begin
            n_errors++; $display("FAIL first_latency: got valid=%b after %0d required 1 after 2", inst_valid, cyc);
        end
        n_checks++;
        if (inst !== 32'h0000_0413 || inst_pc !== RST_PC) begin
            n_errors++; $display("FAIL first_inst: got %h@%h required 00000413@%h", inst, inst_pc, RST_PC);
        end
        tick();
        inst_ready = 1'b0;
        exp_cnt++;
        n_checks++;
        if (fetch_cnt !== 32'(exp_cnt) || inst_valid !== 1'b0) begin
            n_errors++; $display("FAIL first_cnt: got %0d valid=%b required %0d valid=0", fetch_cnt, inst_valid, exp_cnt);
        end
    endtask

    task automatic test_wait_redirect();
        int c0, cyc;
        bit seen;
        c0 = req_count;
        repeat (4) tick();
        n_checks++;
        if (imem_req_valid !== 1'b0 || req_count != c0) begin
            n_errors++; $display("FAIL wait_idle: got req=%b count=%0d required 0 count=%0d", imem_req_valid, req_count, c0);
        end
        send_redirect(32'h8000_0100);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            n_errors++; $display("FAIL wait_req: got %b/%h required 1/80000100", imem_req_valid, imem_req_addr);
        end
        wait_event(20, cyc, seen);
        n_checks++;
        if (!inst_valid || inst_pc !== 32'h8000_0100 || inst !== mem_word(32'h8000_0100)) begin
            n_errors++; $display("FAIL wait_inst: got %b %h@%h required 1 %h@80000100",
                inst_valid, inst, inst_pc, mem_word(32'h8000_0100));
        end
        take_inst();
    endtask

    task automatic test_slow_memory();
        int c0, cyc, held;
        bit stable;
        logic [31:0] tgt;
        tgt = 32'h8000_0200;
        cfg_req_lat = 5; cfg_resp_lat = 3;
        c0 = req_count;
        send_redirect(tgt);
        cyc = 0; held = 0; stable = 1'b1;
        while (!inst_valid && !fetch_fault && cyc < 40) begin
            if (imem_req_valid) begin
                held++;
                if (imem_req_addr !== tgt) stable = 1'b0;
            end
            npc_valid = cyc[0];
            next_pc   = 32'h8000_0F00;
            tick();
            cyc++;
        end
        npc_valid = 1'b0;
        n_checks++;
        if (!inst_valid || cyc != cfg_req_lat + cfg_resp_lat + 2) begin
            n_errors++; $display("FAIL slow_latency: got valid=%b after %0d required 1 after %0d",
                inst_valid, cyc, cfg_req_lat + cfg_resp_lat + 2);
        end
        n_checks++;
        if (!stable || held != cfg_req_lat + 1) begin
            n_errors++; $display("FAIL slow_req_hold: got stable=%b held=%0d required 1 held=%0d", stable, held, cfg_req_lat + 1);
        end
        n_checks++;
        if (req_count - c0 != 1) begin
            n_errors++; $display("FAIL slow_req_count: got %0d required 1", req_count - c0);
        end
        n_checks++;
        if (inst_pc !== tgt || inst !== mem_word(tgt)) begin
            n_errors++; $display("FAIL slow_inst: got %h@%h required %h@%h", inst, inst_pc, mem_word(tgt), tgt);
        end
        take_inst();
        cfg_req_lat = 0; cfg_resp_lat = 0;
    endtask

    task automatic test_access_fault();
        int c0, cyc;
        bit seen;
        cfg_err = 1'b1;
        c0 = req_count;
        send_redirect(32'h8000_0300);
        wait_event(20, cyc, seen);
        n_checks++;
        if ({fetch_fault, fault_cause, inst_valid} !== 3'b100) begin
            n_errors++; $display("FAIL fault_set: got fault/cause/valid=%b%b%b required 100", fetch_fault, fault_cause, inst_valid);
        end
        cfg_err = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || req_count - c0 != 1) begin
            n_errors++; $display("FAIL fault_hold: got fault=%b req=%b reqs=%0d required 1 0 1", fetch_fault, imem_req_valid, req_count - c0);
        end
        send_redirect(32'h8000_0004);
        n_checks++;
        if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
            n_errors++; $display("FAIL fault_clear: got fault=%b req=%b addr=%h required 0 1 80000004", fetch_fault, imem_req_valid, imem_req_addr);
        end
        wait_event(20, cyc, seen);
        n_checks++;
        if (!inst_valid || inst_pc !== 32'h8000_0004 || inst !== mem_word(32'h8000_0004)) begin
            n_errors++; $display("FAIL fault_refetch: got %b %h@%h required 1 %h@80000004", inst_valid, inst, inst_pc, mem_word(32'h8000_0004));
        end
        take_inst();
        n_checks++;
        if (fetch_cnt !== 32'(exp_cnt)) begin
            n_errors++; $display("FAIL fault_cnt: got %0d required %0d", fetch_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        send_redirect(32'h8000_0400);
        wait_event(20, cyc, seen);
        npc_valid = 1'b1; next_pc = 32'h8000_0F00; inst_ready = 1'b0;
        tick();
        npc_valid = 1'b0;
        n_checks++;
        if (!inst_valid || inst_pc !== 32'h8000_0400 || imem_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL b2b_ignore: got valid=%b pc=%h req=%b required 1 80000400 0", inst_valid, inst_pc, imem_req_valid);
        end
        inst_ready = 1'b1; npc_valid = 1'b1; next_pc = 32'h8000_0008;
        tick();
        inst_ready = 1'b0; npc_valid = 1'b0;
        exp_cnt++;
        n_checks++;
        if (fetch_cnt !== 32'(exp_cnt) || inst_valid !== 1'b0) begin
            n_errors++; $display("FAIL b2b_cnt: got %0d valid=%b required %0d valid=0", fetch_cnt, inst_valid, exp_cnt);
        end
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin
            n_errors++; $display("FAIL b2b_req: got %b/%h required 1/80000008", imem_req_valid, imem_req_addr);
        end
        wait_event(20, cyc, seen);
        n_checks++;
        if (!inst_valid || inst_pc !== 32'h8000_0008) begin
            n_errors++; $display("FAIL b2b_inst: got %b@%h required 1@80000008", inst_valid, inst_pc);
        end
        take_inst();
    endtask

    task automatic test_misalign();
        int c0, cyc;
        bit seen;
        c0 = req_count;
        send_redirect(32'h8000_0002);
`ifdef IFU_MISALIGN_TRAP_EN
        n_checks++;
        if ({fetch_fault, fault_cause, imem_req_valid} !== 3'b110 || inst_pc !== 32'h8000_0002) begin
            n_errors++; $display("FAIL mis_trap: got fault/cause/req=%b%b%b pc=%h required 110 80000002",
                fetch_fault, fault_cause, imem_req_valid, inst_pc);
        end
        repeat (3) tick();
        n_checks++;
        if (req_count != c0) begin
            n_errors++; $display("FAIL mis_noreq: got %0d requests required 0", req_count - c0);
        end
        send_redirect(32'h8000_0010);
        wait_event(20, cyc, seen);
        n_checks++;
        if (!inst_valid || fetch_fault !== 1'b0 || inst_pc !== 32'h8000_0010) begin
            n_errors++; $display("FAIL mis_recover: got %b fault=%b pc=%h required 1 0 80000010", inst_valid, fetch_fault, inst_pc);
        end
        take_inst();
`else
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            n_errors++; $display("FAIL mis_mask: got %b/%h required 1/80000000", imem_req_valid, imem_req_addr);
        end
        wait_event(20, cyc, seen);
        n_checks++;
        if (!inst_valid || inst_pc !== 32'h8000_0000 || fetch_fault !== 1'b0 || inst !== 32'h0000_0413) begin
            n_errors++; $display("FAIL mis_fetch: got %b %h@%h fault=%b required 1 00000413@80000000 0", inst_valid, inst, inst_pc, fetch_fault);
        end
        take_inst();
        n_checks++;
        if (req_count - c0 != 1) begin
            n_errors++; $display("FAIL mis_reqs: got %0d required 1", req_count - c0);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] tgt, pend, eff;
        bit have_pend, exp_trap, seen, ok;
        int cyc, hold;
        have_pend = 1'b0;
        pend = '0;
        for (int it = 0; it < 40; it++) begin
            cfg_req_lat  = $urandom_range(0, 3);
            cfg_resp_lat = $urandom_range(0, 3);
            cfg_err      = ($urandom_range(0, 5) == 0);
            if (have_pend) begin
                tgt = pend;
                have_pend = 1'b0;
            end else begin
                tgt = rand_target();
                send_redirect(tgt);
            end
            exp_trap = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            exp_trap = (tgt[1:0] != 2'b00);
`endif
            if (exp_trap) begin
                n_checks++;
                if ({fetch_fault, fault_cause, imem_req_valid} !== 3'b110 || inst_pc !== tgt) begin
                    n_errors++; $display("FAIL rnd_trap[%0d]: got %b%b%b pc=%h required 110 pc=%h",
                        it, fetch_fault, fault_cause, imem_req_valid, inst_pc, tgt);
                end
                continue;
            end
            eff = {tgt[31:2], 2'b00};
            wait_event(60, cyc, seen);
            if (cfg_err) begin
                n_checks++;
                if ({fetch_fault, fault_cause, inst_valid} !== 3'b100) begin
                    n_errors++; $display("FAIL rnd_fault[%0d]: got %b%b%b required 100", it, fetch_fault, fault_cause, inst_valid);
                end
                continue;
            end
            n_checks++;
            if (!inst_valid || fetch_fault || inst_pc !== eff || inst !== mem_word(eff)) begin
                n_errors++; $display("FAIL rnd_inst[%0d]: got %b %h@%h required 1 %h@%h",
                    it, inst_valid, inst, inst_pc, mem_word(eff), eff);
            end
            hold = $urandom_range(0, 3);
            ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                tick();
                if (!inst_valid || inst_pc !== eff || inst !== mem_word(eff)) ok = 1'b0;
            end
            n_checks++;
            if (!ok) begin
                n_errors++; $display("FAIL rnd_hold[%0d]: got %b %h@%h required 1 %h@%h",
                    it, inst_valid, inst, inst_pc, mem_word(eff), eff);
            end
            if ($urandom_range(0, 2) == 0) begin
                pend = rand_target();
                have_pend = 1'b1;
                npc_valid = 1'b1;
                next_pc = pend;
            end
            take_inst();
            npc_valid = 1'b0;
            n_checks++;
            if (fetch_cnt !== 32'(exp_cnt)) begin
                n_errors++; $display("FAIL rnd_cnt[%0d]: got %0d required %0d", it, fetch_cnt, exp_cnt);
            end
        end
        cfg_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        npc_valid = 1'b0;
        next_pc = '0;
        inst_ready = 1'b0;
        tick();
        test_reset();
        test_first_fetch();
        test_wait_redirect();
        test_slow_memory();
        test_access_fault();
        test_back_to_back();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
